alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 Port: req0_ready / req1_ready  output  1  operation accepted this cycle.
REQ-006 Port: req0_a, req0_b / req1_a, req1_b  input  32  operands (a drives ALU in1, b drives ALU in2).
REQ-007 Port: req0_op / req1_op  input  3  ALU control code.
REQ-008 Port: resp0_valid / resp1_valid  output  1  result ready for requester N.
REQ-009 Port: resp0_ready / resp1_ready  input  1  requester N consumes the result.
REQ-010 Port: resp_data  output  32  shared result bus.
REQ-011 Port: resp_zero, resp_msb, resp_carry  output  1  shared flag bus.
REQ-012 Port: alu_in1, alu_in2  output  32  operands to the ALU.
REQ-013 Port: alu_ctrl  output  3  ALU control.
REQ-014 Port: alu_out  input  32  ALU result.
REQ-015 Port: alu_zero, alu_msb, alu_carry  input  1  ALU flags.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP. At most one transaction SHALL be outstanding.
REQ-017 IDLE: if any reqN_valid is high, the block SHALL grant one requester, assert its reqN_ready combinationally in that cycle, register a, b, op and the grant ID, and move to EXEC.
REQ-018 reqN_ready SHALL be low in EXEC and RESP, and low for the non-granted requester.
REQ-019 Round-robin: when both requesters are valid, the grant SHALL go to the requester not granted last. When only one is valid, it SHALL be granted regardless of the pointer.
REQ-020 The last-grant pointer SHALL update only on grant. At reset it SHALL be 1, so req0 wins the first tie.
REQ-021 alu_in1, alu_in2 and alu_ctrl SHALL be driven only from the operand registers and SHALL stay stable from EXEC until the next grant.
REQ-022 EXEC: at the end of the cycle the block SHALL capture alu_out, alu_zero and alu_msb into result registers, then move to RESP.
REQ-023 Carry: resp_carry SHALL be the captured alu_carry when op==0 (add) and 0 for every other op, because the ALU carry output is stale outside add.
REQ-024 RESP: respN_valid SHALL be high only for the granted requester. resp_data and the resp flags SHALL hold the captured values.
REQ-025 RESP SHALL hold until respN_ready is high for the granted requester, then return to IDLE. No new grant SHALL occur in that same cycle.
REQ-026 Latency: for a grant in cycle N, respN_valid SHALL rise in cycle N+2. Maximum throughput SHALL be one operation per 3 cycles.
REQ-027 resp_ready from the non-granted requester SHALL be ignored.
REQ-028 reqN_valid deasserting while the request is not granted is legal. Operands SHALL be sampled only in the grant cycle.

Reset
REQ-029 While rst is high, the block SHALL be in IDLE.
REQ-030 While rst is high, all outputs SHALL be 0: ready, resp_valid, resp_data, flags, alu_in1/in2/ctrl.
REQ-031 While rst is high, the last-grant pointer SHALL be 1.
REQ-032 Reset asserted mid-transaction SHALL drop that transaction with no response.

Structure
REQ-033 Shared package alu_arb_pkg SHALL hold:
- FSM state encoding (IDLE/EXEC/RESP);
- ALU op constants: ADD=0, COMP=1, SL=2, SRL=3, SRA=4, DIFF=5, AND=6, XOR=7.
REQ-034 One sub-module, rr_arb2, SHALL implement the 2-way round-robin grant and the pointer.
REQ-035 The ALU SHALL stay external. The arbiter SHALL connect to it only through the alu_* ports.

Verification
REQ-036 Single request: req0 add, a=0xFFFFFFFF, b=1 -> resp0_valid at grant+2; resp_data=0, resp_carry=1, resp_zero=0, resp_msb=1.
REQ-037 Tie after reset: both valid in one cycle -> req0 granted first, req1 granted in the next IDLE; each result is routed to the correct resp_valid.
REQ-038 Carry masking: req1 XOR op, a=0, b=5, after a prior add that set the ALU carry -> resp_data=5, resp_carry=0, resp_zero=1.
REQ-039 Backpressure: resp0_ready held low 4 cycles -> resp0_valid and resp_data stay stable; no grant occurs until the ready handshake completes.
REQ-040 Reset in EXEC: assert rst -> all outputs 0 immediately; no response after release; next tie grants req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: FSM states and ALU op codes.
// Also holds the rule for when the ALU carry flag is meaningful.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_COMP = 3'd1;
  localparam logic [2:0] OP_SL   = 3'd2;
  localparam logic [2:0] OP_SRL  = 3'd3;
  localparam logic [2:0] OP_SRA  = 3'd4;
  localparam logic [2:0] OP_DIFF = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  // The ALU only refreshes carry on add; otherwise it is stale.
  function automatic logic carry_live(logic [2:0] op);
    return op == OP_ADD;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with last-grant pointer.
// Ports: en gates granting, req in, gnt one-hot out, gnt_id = gnt[1].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last;

  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (1'b1)
        (req[0] && !req[1]): gnt = 2'b01;
        (!req[0] && req[1]): gnt = 2'b10;
        (req[0] && req[1]):  gnt = last ? 2'b01 : 2'b10;
        default:             gnt = '0;
      endcase
    end
  end

  assign gnt_id = gnt[1];

  // Reset value 1 lets req0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one op in flight.
// Ports: reqN_* request handshakes, respN_* result handshakes, alu_* ALU link.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_msb,
  output logic             resp_carry,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_msb,
  input  logic             alu_carry
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             msb_q;
  logic             carry_q;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             arb_en;
  logic             resp_done;

  // rst gating keeps ready low while reset is held.
  assign arb_en = (state == ST_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req    ({req1_valid, req0_valid}),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign resp0_valid = (state == ST_RESP) && !id_q;
  assign resp1_valid = (state == ST_RESP) && id_q;

  // Only the granted requester's ready closes the response.
  assign resp_done = id_q ? resp1_ready : resp0_ready;

  assign alu_in1  = a_q;
  assign alu_in2  = b_q;
  assign alu_ctrl = op_q;

  assign resp_data  = res_q;
  assign resp_zero  = zero_q;
  assign resp_msb   = msb_q;
  assign resp_carry = carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      msb_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|gnt) begin
            a_q   <= gnt_id ? req1_a : req0_a;
            b_q   <= gnt_id ? req1_b : req0_b;
            op_q  <= gnt_id ? req1_op : req0_op;
            id_q  <= gnt_id;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= alu_out;
          zero_q  <= alu_zero;
          msb_q   <= alu_msb;
          carry_q <= alu_carry & carry_live(op_q);
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached.
// Grants, responses and results are checked against a reference model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp_data;
  logic        resp_zero, resp_msb, resp_carry;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_msb, alu_carry;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .resp_msb(resp_msb), .resp_carry(resp_carry),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_msb(alu_msb), .alu_carry(alu_carry)
  );

  function automatic logic [31:0] alu_fn(logic [2:0] op,
                                         logic [31:0] a,
                                         logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return {31'd0, $signed(a) < $signed(b)};
      3'd2: return a << b[4:0];
      3'd3: return a >> b[4:0];
      3'd4: return 32'($signed(a) >>> b[4:0]);
      3'd5: return a - b;
      3'd6: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic add_cy(logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32];
  endfunction

  // External ALU: zero/msb describe operand 1; carry is held
  // from the last add whenever a non-add op is applied.
  logic last_c = 1'b0;
  always @(posedge clk)
    if (alu_ctrl == OP_ADD) last_c <= add_cy(alu_in1, alu_in2);
  assign alu_out   = alu_fn(alu_ctrl, alu_in1, alu_in2);
  assign alu_zero  = (alu_in1 == 32'd0);
  assign alu_msb   = alu_in1[31];
  assign alu_carry = (alu_ctrl == OP_ADD) ? add_cy(alu_in1, alu_in2)
                                          : last_c;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        z, m, c;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic last_g = 1'b1;
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endfunction

  function automatic exp_t model(logic id, logic [2:0] op,
                                 logic [31:0] a, logic [31:0] b,
                                 int gc);
    exp_t e;
    e.id   = id;
    e.data = alu_fn(op, a, b);
    e.z    = (a == 32'd0);
    e.m    = a[31];
    e.c    = (op == OP_ADD) ? add_cy(a, b) : 1'b0;
    e.gcyc = gc;
    return e;
  endfunction

  // Monitor: grant check first (before any pop), then responses.
  exp_t       e;
  logic       want;
  logic [1:0] rdys;
  always @(negedge clk) begin
    if (!rst) begin
      rdys = {req1_ready, req0_ready};
      if (sb.size() == 0) begin
        if (!req0_valid && !req1_valid) begin
          chk("grant_none", 64'(rdys), 64'd0);
        end else begin
          want = (req0_valid && req1_valid) ? ~last_g : req1_valid;
          chk("grant", 64'(rdys), want ? 64'd2 : 64'd1);
          if (rdys == 2'b01 || rdys == 2'b10) begin
            last_g = rdys[1];
            if (rdys[1]) begin
              sb.push_back(model(1'b1, req1_op, req1_a, req1_b, cyc));
              acc1 = 1'b1;
            end else begin
              sb.push_back(model(1'b0, req0_op, req0_a, req0_b, cyc));
              acc0 = 1'b1;
            end
          end
        end
      end else begin
        chk("grant_busy", 64'(rdys), 64'd0);
      end
      if (sb.size() == 0) begin
        chk("resp_idle", {62'd0, resp1_valid, resp0_valid}, 64'd0);
      end else begin
        e = sb[0];
        if (cyc - e.gcyc < 2) begin
          chk("resp_early", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        end else begin
          chk("resp_valid", {62'd0, resp1_valid, resp0_valid},
              e.id ? 64'd2 : 64'd1);
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_flags", {61'd0, resp_zero, resp_msb, resp_carry},
              {61'd0, e.z, e.m, e.c});
          if (e.id ? resp1_ready : resp0_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic chk_rst_out();
    chk("rst_hs", {60'd0, req0_ready, req1_ready,
                   resp0_valid, resp1_valid}, 64'd0);
    chk("rst_resp", {29'd0, resp_data, resp_zero, resp_msb,
                     resp_carry}, 64'd0);
    chk("rst_alu", {alu_in1, alu_in2}, 64'd0);
    chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
  endtask

  task automatic req(input logic id, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
  endtask

  task automatic wait_acc(input logic id);
    int n;
    n = 0;
    while (!(id ? acc1 : acc0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    total++;
    if (!(id ? acc1 : acc0)) begin
      bad++;
      $display("FAIL grant_timeout id=%0d actual=none required=grant", id);
    end
    if (id) begin acc1 = 1'b0; req1_valid = 1'b0; end
    else    begin acc0 = 1'b0; req0_valid = 1'b0; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd3; req0_b = 32'd4; req0_op = OP_ADD;
    req1_a = 32'd5; req1_b = 32'd6; req1_op = OP_AND;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #12;
    chk_rst_out();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Tie after reset: add with carry, then xor with stale carry.
    req(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    req(1'b1, OP_XOR, 32'd0, 32'd5);
    fork
      wait_acc(1'b0);
      wait_acc(1'b1);
    join
    drain();

    // Single request.
    req(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    wait_acc(1'b0);
    drain();

    // Backpressure while the other side keeps asking.
    resp0_ready = 1'b0;
    req(1'b0, OP_SRA, 32'h8000_00F0, 32'd4);
    wait_acc(1'b0);
    req(1'b1, OP_DIFF, 32'd7, 32'd9);
    n = 0;
    while (!resp0_valid && n < 10) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("bp_hold", 64'(resp0_valid), 64'd1);
    resp0_ready = 1'b1;
    wait_acc(1'b1);
    drain();

    // Reset during EXEC drops the transaction.
    req(1'b0, OP_SL, 32'd1, 32'd31);
    wait_acc(1'b0);
    rst = 1'b1;
    sb.delete();
    acc0 = 1'b0; acc1 = 1'b0;
    last_g = 1'b1;
    req(1'b0, OP_COMP, 32'hFFFF_FFFE, 32'd1);
    req(1'b1, OP_SRL, 32'h8000_0000, 32'd31);
    #1;
    chk_rst_out();
    @(posedge clk); #1 rst = 1'b0;
    fork
      wait_acc(1'b0);
      wait_acc(1'b1);
    join
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (acc0) begin
        acc0 = 1'b0;
        req0_valid = 1'b0;
      end else if (req0_valid) begin
        if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
        else if ($urandom_range(0, 7) == 0) req0_a = rnd32();
      end else if ($urandom_range(0, 1) == 1) begin
        req(1'b0, 3'($urandom_range(0, 7)), rnd32(), rnd32());
      end
      if (acc1) begin
        acc1 = 1'b0;
        req1_valid = 1'b0;
      end else if (req1_valid) begin
        if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
        else if ($urandom_range(0, 7) == 0) req1_b = rnd32();
      end else if ($urandom_range(0, 1) == 1) begin
        req(1'b1, 3'($urandom_range(0, 7)), rnd32(), rnd32());
      end
      resp0_ready = ($urandom_range(0, 2) != 0);
      resp1_ready = ($urandom_range(0, 2) != 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
